// File: rtl/cnn_mul_acc_pipe.sv
// Pipelined signed multiply-accumulate for CNN dot products: NUM_STAGE product registers,
// one accumulate stage, and one round/saturate output register, all frozen by output backpressure.
module cnn_mul_acc_pipe #(
  parameter int DIN0_WIDTH = 11,
  parameter int DIN1_WIDTH = 15,
  parameter int NUM_STAGE  = 3,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_SHIFT = 9,
  parameter int DOUT_WIDTH = 15
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat_flag
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  // Rounding and clipping work one bit wider than the accumulator so the +half never wraps.
  localparam logic signed [ACC_WIDTH:0] RND_HALF =
    (ACC_WIDTH+1)'(64'sd1 <<< (FRAC_SHIFT - 1));
  localparam logic signed [ACC_WIDTH:0] DOUT_MAX =
    (ACC_WIDTH+1)'((64'sd1 <<< (DOUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] DOUT_MIN =
    (ACC_WIDTH+1)'(-(64'sd1 <<< (DOUT_WIDTH - 1)));

  // Handshake: in_vld/in_rdy accept a beat on the rising edge when both are 1;
  // out_vld/out_rdy retire a result the same way. A pending unretired result
  // (out_vld=1, out_rdy=0) freezes every register, which is exactly when in_rdy drops.
  logic adv;

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [PROD_WIDTH-1:0] prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]         vld_q;
  logic [NUM_STAGE-1:0]         first_q;
  logic [NUM_STAGE-1:0]         last_q;

  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         acc_done_q, acc_done_d;

  logic signed [ACC_WIDTH:0]    rnd_sum;
  logic signed [ACC_WIDTH:0]    rnd_shift;
  logic                         sat_hi, sat_lo;
  logic signed [DOUT_WIDTH-1:0] dout_d, dout_q;
  logic                         sat_d, sat_q;
  logic                         out_vld_q;

  assign adv    = ~(out_vld_q & ~out_rdy);
  assign in_rdy = adv;

  assign prod = PROD_WIDTH'(din0) * PROD_WIDTH'(din1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int s = 0; s < NUM_STAGE; s++) prod_q[s] <= '0;
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (adv) begin
      prod_q[0]  <= prod;
      vld_q[0]   <= in_vld;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      for (int s = 1; s < NUM_STAGE; s++) begin
        prod_q[s]  <= prod_q[s-1];
        vld_q[s]   <= vld_q[s-1];
        first_q[s] <= first_q[s-1];
        last_q[s]  <= last_q[s-1];
      end
    end
  end

  assign prod_ext = ACC_WIDTH'(prod_q[NUM_STAGE-1]);

  always_comb begin
    acc_d      = acc_q;
    acc_done_d = vld_q[NUM_STAGE-1] & last_q[NUM_STAGE-1];
    if (vld_q[NUM_STAGE-1]) begin
      acc_d = first_q[NUM_STAGE-1] ? prod_ext : acc_q + prod_ext;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q      <= '0;
      acc_done_q <= 1'b0;
    end else if (adv) begin
      acc_q      <= acc_d;
      acc_done_q <= acc_done_d;
    end
  end

  always_comb begin
    rnd_sum   = (ACC_WIDTH+1)'(acc_q) + RND_HALF;
    rnd_shift = rnd_sum >>> FRAC_SHIFT;
    sat_hi    = rnd_shift > DOUT_MAX;
    sat_lo    = rnd_shift < DOUT_MIN;
    sat_d     = sat_hi | sat_lo;
    if (sat_hi)      dout_d = DOUT_MAX[DOUT_WIDTH-1:0];
    else if (sat_lo) dout_d = DOUT_MIN[DOUT_WIDTH-1:0];
    else             dout_d = rnd_shift[DOUT_WIDTH-1:0];
  end

  // When not stalled, either no result is pending or it is being retired this edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_vld_q <= 1'b0;
      dout_q    <= '0;
      sat_q     <= 1'b0;
    end else if (adv) begin
      out_vld_q <= acc_done_q;
      if (acc_done_q) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign out_vld  = out_vld_q;
  assign dout     = dout_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_cnn_mul_acc_pipe.sv
// Directed bench for cnn_mul_acc_pipe: default pipeline plus NUM_STAGE=1 and 6 copies for latency sweep.
module tb_cnn_mul_acc_pipe;

  localparam int DW = 15;

  logic ap_clk, ap_rst_n, in_vld, in_first, in_last, out_rdy, rdy_one;
  logic signed [10:0] din0;
  logic signed [14:0] din1;
  logic in_rdy, out_vld, sat_flag;
  logic signed [DW-1:0] dout;
  logic s1_in_rdy, s1_out_vld, s1_sat;
  logic signed [DW-1:0] s1_dout;
  logic s6_in_rdy, s6_out_vld, s6_sat;
  logic signed [DW-1:0] s6_dout;

  int cyc;
  int checks;
  int errors;

  logic [DW-1:0] got_q[$];
  logic          got_sat_q[$];
  int            got_cyc_q[$];
  logic [DW-1:0] s1_q[$];
  int            s1_cyc_q[$];
  logic [DW-1:0] s6_q[$];
  int            s6_cyc_q[$];
  logic [DW-1:0] exp_q[$];

  cnn_mul_acc_pipe dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_vld(out_vld), .out_rdy(out_rdy), .dout(dout), .sat_flag(sat_flag)
  );

  cnn_mul_acc_pipe #(.NUM_STAGE(1)) dut_s1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_vld(in_vld), .in_rdy(s1_in_rdy),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_vld(s1_out_vld), .out_rdy(rdy_one), .dout(s1_dout), .sat_flag(s1_sat)
  );

  cnn_mul_acc_pipe #(.NUM_STAGE(6)) dut_s6 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_vld(in_vld), .in_rdy(s6_in_rdy),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_vld(s6_out_vld), .out_rdy(rdy_one), .dout(s6_dout), .sat_flag(s6_sat)
  );

  // clock / reset
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Result collectors: a result is retired on the posedge following a negedge that sees vld&rdy.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_vld && out_rdy) begin
      got_q.push_back(dout);
      got_sat_q.push_back(sat_flag);
      got_cyc_q.push_back(cyc);
    end
    if (ap_rst_n && s1_out_vld) begin
      s1_q.push_back(s1_dout);
      s1_cyc_q.push_back(cyc);
    end
    if (ap_rst_n && s6_out_vld) begin
      s6_q.push_back(s6_dout);
      s6_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] ev(input int v);
    return DW'(v);
  endfunction

  task automatic clear_queues();
    got_q.delete(); got_sat_q.delete(); got_cyc_q.delete();
    s1_q.delete(); s1_cyc_q.delete(); s6_q.delete(); s6_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    in_vld   = 1'b0;
    out_rdy  = 1'b1;
    clear_queues();
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
  endtask

  // driver tasks: called at posedge+1, return at posedge+1 after the accepting edge
  task automatic send_beat(input int a, input int b, input logic f, input logic l,
                           output int acc_cyc);
    int n;
    in_vld = 1'b1; din0 = a[10:0]; din1 = b[14:0]; in_first = f; in_last = l;
    n = 0;
    @(negedge ap_clk);
    while (!in_rdy && n < 200) begin
      n++;
      @(negedge ap_clk);
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout: in_rdy stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge ap_clk);
    #1;
    acc_cyc = cyc;
    in_vld  = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int a[4], input int b, output int last_cyc);
    for (int i = 0; i < n; i++) send_beat(a[i], b, i == 0, i == n - 1, last_cyc);
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 100) begin
      @(posedge ap_clk); #1; k++;
    end
    repeat (8) @(posedge ap_clk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    ap_rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; rdy_one = 1'b1;
    in_first = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
    #3;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
    checks++; if (dout !== ev(0)) begin errors++; $display("FAIL reset_dout: got %0d want 0", dout); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
    do_reset();
  endtask

  task automatic test_single();
    int c;
    do_reset();
    send_beat(3, 512, 1'b1, 1'b1, c);
    wait_got(1);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d results want 1", got_q.size()); end
    else begin
      checks++; if (got_cyc_q[0] - c != 4) begin errors++; $display("FAIL single_latency: got %0d want 4", got_cyc_q[0] - c); end
      checks++; if (got_q[0] !== ev(3)) begin errors++; $display("FAIL single_dout: got %0d want 3", $signed(got_q[0])); end
      checks++; if (got_sat_q[0] !== 1'b0) begin errors++; $display("FAIL single_sat: got %b want 0", got_sat_q[0]); end
    end
  endtask

  task automatic test_no_first();
    int c;
    do_reset();
    send_beat(4, 512, 1'b0, 1'b1, c);
    wait_got(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== ev(4)) begin
      errors++; $display("FAIL no_first_dout: got %0d results, first %0d, want one result 4",
                         got_q.size(), got_q.size() > 0 ? $signed(got_q[0]) : 0);
    end
  endtask

  task automatic test_packet();
    int c;
    do_reset();
    send_pkt(4, '{100, -50, 20, 1}, 512, c);
    wait_got(1);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL packet_count: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== ev(71)) begin errors++; $display("FAIL packet_dout: got %0d want 71", $signed(got_q[0])); end
      checks++; if (got_cyc_q[0] - c != 4) begin errors++; $display("FAIL packet_latency: got %0d want 4", got_cyc_q[0] - c); end
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1, c2;
    do_reset();
    send_beat(1, 256, 1'b1, 1'b1, c0);
    send_beat(1, 255, 1'b1, 1'b1, c1);
    send_beat(-1, 256, 1'b1, 1'b1, c2);
    wait_got(3);
    checks++;
    if (c1 != c0 + 1 || c2 != c1 + 1) begin errors++; $display("FAIL b2b_accept: got cycles %0d %0d %0d want consecutive", c0, c1, c2); end
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== ev(1)) begin errors++; $display("FAIL round_256: got %0d want 1", $signed(got_q[0])); end
      checks++; if (got_q[1] !== ev(0)) begin errors++; $display("FAIL round_255: got %0d want 0", $signed(got_q[1])); end
      checks++; if (got_q[2] !== ev(0)) begin errors++; $display("FAIL round_neg256: got %0d want 0", $signed(got_q[2])); end
      checks++;
      if (got_cyc_q[1] != got_cyc_q[0] + 1 || got_cyc_q[2] != got_cyc_q[1] + 1) begin
        errors++; $display("FAIL b2b_out_cycles: got %0d %0d %0d want consecutive", got_cyc_q[0], got_cyc_q[1], got_cyc_q[2]);
      end
    end
  endtask

  task automatic test_saturation();
    int c;
    do_reset();
    send_pkt(4, '{-1024, -1024, -1024, -1024}, -16384, c);
    send_pkt(4, '{1023, 1023, 1023, 1023}, -16384, c);
    wait_got(2);
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL sat_count: got %0d want 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== ev(16383)) begin errors++; $display("FAIL sat_pos_dout: got %0d want 16383", $signed(got_q[0])); end
      checks++; if (got_sat_q[0] !== 1'b1) begin errors++; $display("FAIL sat_pos_flag: got %b want 1", got_sat_q[0]); end
      checks++; if (got_q[1] !== ev(-16384)) begin errors++; $display("FAIL sat_neg_dout: got %0d want -16384", $signed(got_q[1])); end
      checks++; if (got_sat_q[1] !== 1'b1) begin errors++; $display("FAIL sat_neg_flag: got %b want 1", got_sat_q[1]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fork
      begin
        int c;
        for (int k = 0; k < 10; k++) begin
          send_beat(k * 7 - 20, 512, 1'b1, 1'b0, c);
          send_beat(3, 512, 1'b0, 1'b1, c);
          exp_q.push_back(ev(k * 7 - 17));
        end
      end
      begin
        int n;
        logic [DW-1:0] held;
        n = 0;
        @(posedge ap_clk); #1;
        while (!out_vld && n < 100) begin
          @(posedge ap_clk); #1; n++;
        end
        out_rdy = 1'b0;
        held = dout;
        for (int i = 0; i < 5; i++) begin
          @(negedge ap_clk);
          checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL stall_in_rdy[%0d]: got %b want 0", i, in_rdy); end
          checks++; if (dout !== held || out_vld !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %0d/%b want %0d/1", i, dout, out_vld, $signed(held)); end
        end
        @(posedge ap_clk); #1;
        out_rdy = 1'b1;
      end
    join
    wait_got(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_order[%0d]: got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    out_rdy = 1'b0;
    send_beat(5, 512, 1'b1, 1'b1, c);
    send_beat(7, 512, 1'b1, 1'b0, c);
    send_beat(9, 512, 1'b0, 1'b0, c);
    repeat (3) @(posedge ap_clk);
    #1;
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL midrst_pre_vld: got %b want 1", out_vld); end
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL midrst_async_vld: got %b want 0", out_vld); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL midrst_in_rdy: got %b want 1", in_rdy); end
    checks++; if (dout !== ev(0) || sat_flag !== 1'b0) begin errors++; $display("FAIL midrst_dout: got %0d/%b want 0/0", dout, sat_flag); end
    clear_queues();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    out_rdy  = 1'b1;
    send_beat(2, 512, 1'b1, 1'b1, c);
    wait_got(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== ev(2)) begin
      errors++; $display("FAIL midrst_result: got %0d results, first %0d, want one result 2",
                         got_q.size(), got_q.size() > 0 ? $signed(got_q[0]) : 0);
    end
  endtask

  task automatic test_stage_sweep();
    int c, k;
    do_reset();
    send_pkt(4, '{100, -50, 20, 1}, 512, c);
    k = 0;
    while (s6_q.size() < 1 && k < 100) begin
      @(posedge ap_clk); #1; k++;
    end
    checks++;
    if (got_q.size() != 1 || s1_q.size() != 1 || s6_q.size() != 1) begin
      errors++; $display("FAIL sweep_count: got %0d/%0d/%0d want 1/1/1", got_q.size(), s1_q.size(), s6_q.size());
    end else begin
      checks++; if (s1_cyc_q[0] - c != 2) begin errors++; $display("FAIL sweep_lat_s1: got %0d want 2", s1_cyc_q[0] - c); end
      checks++; if (s6_cyc_q[0] - c != 7) begin errors++; $display("FAIL sweep_lat_s6: got %0d want 7", s6_cyc_q[0] - c); end
      checks++; if (got_cyc_q[0] - c != 4) begin errors++; $display("FAIL sweep_lat_s3: got %0d want 4", got_cyc_q[0] - c); end
      checks++; if (s1_q[0] !== ev(71)) begin errors++; $display("FAIL sweep_dout_s1: got %0d want 71", $signed(s1_q[0])); end
      checks++; if (s6_q[0] !== ev(71)) begin errors++; $display("FAIL sweep_dout_s6: got %0d want 71", $signed(s6_q[0])); end
    end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    test_reset();
    test_single();
    test_no_first();
    test_packet();
    test_back_to_back();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_stage_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
